// File: rtl/pio_rr_arbiter.sv
// Two-master round-robin arbiter in front of a single Avalon-MM PIO slave.
// A lock input lets one master hold the slave across a read-modify-write sequence.
module pio_rr_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              m0_chipselect,
    input  logic              m0_write_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_lock,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,

    input  logic              m1_chipselect,
    input  logic              m1_write_n,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_lock,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,

    output logic              s_chipselect,
    output logic              s_write_n,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   lock_vld_q, lock_vld_d;
    logic   lock_own_q, lock_own_d;

    logic   ownerAbandoned;
    logic   lockHeld;
    logic   elig0;
    logic   elig1;

    // An owner sitting idle with both chipselect and lock low gives the lock up at once.
    always_comb begin
        ownerAbandoned = lock_own_q ? (~m1_chipselect & ~m1_lock)
                                    : (~m0_chipselect & ~m0_lock);
        lockHeld       = lock_vld_q & ~ownerAbandoned;
        elig0          = m0_chipselect & (~lockHeld | ~lock_own_q);
        elig1          = m1_chipselect & (~lockHeld |  lock_own_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            lock_vld_q <= 1'b0;
            lock_own_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        case (state_q)
            IDLE: begin
                lock_vld_d = lockHeld;
                if (elig0 && elig1) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (elig0) begin
                    state_d = GNT0;
                end else if (elig1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                state_d    = IDLE;
                last_d     = 1'b0;
                lock_vld_d = m0_lock;
                lock_own_d = 1'b0;
            end
            GNT1: begin
                state_d    = IDLE;
                last_d     = 1'b1;
                lock_vld_d = m1_lock;
                lock_own_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Slave bus is parked idle and read data is zeroed outside a grant cycle.
    always_comb begin
        s_chipselect   = 1'b0;
        s_write_n      = 1'b1;
        s_address      = '0;
        s_writedata    = '0;
        m0_readdata    = '0;
        m1_readdata    = '0;
        m0_waitrequest = m0_chipselect & (state_q != GNT0);
        m1_waitrequest = m1_chipselect & (state_q != GNT1);
        case (state_q)
            GNT0: begin
                s_chipselect = 1'b1;
                s_write_n    = m0_write_n;
                s_address    = m0_address;
                s_writedata  = m0_writedata;
                m0_readdata  = s_readdata;
            end
            GNT1: begin
                s_chipselect = 1'b1;
                s_write_n    = m1_write_n;
                s_address    = m1_address;
                s_writedata  = m1_writedata;
                m1_readdata  = s_readdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_pio_rr_arbiter.sv
// Bench for pio_rr_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level arbiter model and a PIO latch model.
module tb_pio_rr_arbiter;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;

    typedef struct {
        logic              wn;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              lock;
        int                idleBefore;
    } req_t;

    typedef struct {
        int                m;
        int                cyc;
        logic [DATA_W-1:0] rd;
        int                waits;
    } comp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic              cs   [2];
    logic              wn   [2];
    logic [ADDR_W-1:0] addr [2];
    logic [DATA_W-1:0] wd   [2];
    logic              lk   [2];
    logic [DATA_W-1:0] rd   [2];
    logic              wr   [2];

    logic              sCs;
    logic              sWn;
    logic [ADDR_W-1:0] sAddr;
    logic [DATA_W-1:0] sWd;
    logic [DATA_W-1:0] sRd;

    // PIO output latch: only address 0 is the data register
    logic [7:0] outPort;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           outPort <= 8'h00;
        else if (sCs && !sWn && sAddr == 2'd0)  outPort <= sWd[7:0];
    end
    assign sRd = (sAddr == 2'd0) ? {24'd0, outPort} : 32'd0;

    pio_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_chipselect(cs[0]), .m0_write_n(wn[0]), .m0_address(addr[0]),
        .m0_writedata(wd[0]), .m0_lock(lk[0]), .m0_readdata(rd[0]), .m0_waitrequest(wr[0]),
        .m1_chipselect(cs[1]), .m1_write_n(wn[1]), .m1_address(addr[1]),
        .m1_writedata(wd[1]), .m1_lock(lk[1]), .m1_readdata(rd[1]), .m1_waitrequest(wr[1]),
        .s_chipselect(sCs), .s_write_n(sWn), .s_address(sAddr),
        .s_writedata(sWd), .s_readdata(sRd)
    );

    int assertCount = 0;
    int failCount   = 0;

    // reference model: who owns the current cycle, who was served last, who holds the lock
    int         mGrantee;
    int         mLast;
    int         mOwner;
    logic [7:0] mPort;

    req_t  reqQ0[$];
    req_t  reqQ1[$];
    comp_t compLog[$];
    logic  doneFlag   [2];
    int    issueCycle [2];
    int    cycleCount = 0;
    int    sCsCount   = 0;
    bit    randMode   = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycleCount);
        end
    endtask

    task automatic modelReset();
        mGrantee = -1;
        mLast    = 1;
        mOwner   = -1;
        mPort    = 8'h00;
    endtask

    function automatic logic [DATA_W-1:0] portRead(input logic [ADDR_W-1:0] a);
        return (a == 2'd0) ? {24'd0, mPort} : 32'd0;
    endfunction

    function automatic int qSize(input int x);
        return (x == 0) ? reqQ0.size() : reqQ1.size();
    endfunction

    function automatic int frontIdle(input int x);
        return (x == 0) ? reqQ0[0].idleBefore : reqQ1[0].idleBefore;
    endfunction

    task automatic decIdle(input int x);
        if (x == 0) reqQ0[0].idleBefore = reqQ0[0].idleBefore - 1;
        else        reqQ1[0].idleBefore = reqQ1[0].idleBefore - 1;
    endtask

    task automatic qPop(input int x, output req_t r);
        if (x == 0) r = reqQ0.pop_front();
        else        r = reqQ1.pop_front();
    endtask

    task automatic pushReq(input int x, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic l, input int idle);
        req_t r;
        r.wn = w; r.addr = a; r.data = d; r.lock = l; r.idleBefore = idle;
        if (x == 0) reqQ0.push_back(r);
        else        reqQ1.push_back(r);
    endtask

    task automatic clearAgents();
        for (int x = 0; x < 2; x++) begin
            cs[x] = 1'b0; wn[x] = 1'b1; addr[x] = '0; wd[x] = '0; lk[x] = 1'b0;
            doneFlag[x] = 1'b0; issueCycle[x] = 0;
        end
        reqQ0.delete();
        reqQ1.delete();
    endtask

    // Compare every DUT output with the model, then advance the model by one clock.
    task automatic checkAndAdvanceModel();
        int g;
        int gi;
        bit e0;
        bit e1;
        g  = mGrantee;
        gi = (g < 0) ? 0 : g;
        checkOutput("s_chipselect", 64'(sCs),   64'(g >= 0));
        checkOutput("s_write_n",    64'(sWn),   64'((g >= 0) ? wn[gi] : 1'b1));
        checkOutput("s_address",    64'(sAddr), 64'((g >= 0) ? addr[gi] : 2'd0));
        checkOutput("s_writedata",  64'(sWd),   64'((g >= 0) ? wd[gi] : 32'd0));
        for (int x = 0; x < 2; x++) begin
            checkOutput($sformatf("m%0d_readdata", x), 64'(rd[x]),
                        64'((g == x) ? portRead(addr[x]) : 32'd0));
            checkOutput($sformatf("m%0d_waitrequest", x), 64'(wr[x]), 64'(cs[x] && (g != x)));
        end
        checkOutput("out_port", 64'(outPort), 64'(mPort));

        if (g >= 0) begin
            if (!wn[g] && addr[g] == 2'd0) mPort = wd[g][7:0];
            mLast    = g;
            mOwner   = lk[g] ? g : -1;
            mGrantee = -1;
        end else begin
            if (mOwner >= 0 && !cs[mOwner] && !lk[mOwner]) mOwner = -1;
            e0 = cs[0] && (mOwner < 0 || mOwner == 0);
            e1 = cs[1] && (mOwner < 0 || mOwner == 1);
            if (e0 && e1)  mGrantee = 1 - mLast;
            else if (e0)   mGrantee = 0;
            else if (e1)   mGrantee = 1;
            else           mGrantee = -1;
        end
    endtask

    // Master agents: retire finished transfers, issue queued ones, random traffic.
    task automatic applyStimulus();
        req_t r;
        for (int x = 0; x < 2; x++) begin
            if (doneFlag[x]) begin
                cs[x] = 1'b0;
                doneFlag[x] = 1'b0;
                if (qSize(x) == 0) lk[x] = 1'b0;
            end
            if (randMode) begin
                if (!cs[x] && qSize(x) == 0 && $urandom_range(0, 3) == 0) begin
                    pushReq(x, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                            ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
                end else if (cs[x] && mGrantee != x && $urandom_range(0, 15) == 0) begin
                    cs[x] = 1'b0;
                    lk[x] = 1'($urandom_range(0, 1));
                end
            end
            if (!cs[x] && qSize(x) > 0) begin
                if (frontIdle(x) > 0) begin
                    decIdle(x);
                end else begin
                    qPop(x, r);
                    cs[x] = 1'b1; wn[x] = r.wn; addr[x] = r.addr; wd[x] = r.data; lk[x] = r.lock;
                    issueCycle[x] = cycleCount;
                end
            end
        end
    endtask

    task automatic runCycle();
        comp_t c;
        @(negedge clk);
        checkAndAdvanceModel();
        if (sCs) sCsCount++;
        for (int x = 0; x < 2; x++) begin
            if (cs[x] && !wr[x]) begin
                doneFlag[x] = 1'b1;
                c.m = x; c.cyc = cycleCount; c.rd = rd[x]; c.waits = cycleCount - issueCycle[x];
                compLog.push_back(c);
            end
        end
        cycleCount++;
        @(posedge clk);
        #1;
        applyStimulus();
    endtask

    task automatic runUntilIdle(input int budget);
        int n;
        bit timedOut;
        n = 0;
        while ((cs[0] || cs[1] || qSize(0) > 0 || qSize(1) > 0 || doneFlag[0] || doneFlag[1]) && n < budget) begin
            runCycle();
            n++;
        end
        timedOut = (n >= budget);
        checkOutput("drain_timeout", 64'(timedOut), 64'd0);
    endtask

    initial begin
        clearAgents();
        modelReset();

        // reset state
        #2;
        checkOutput("rst_s_chipselect", 64'(sCs), 64'd0);
        checkOutput("rst_s_write_n", 64'(sWn), 64'd1);
        checkOutput("rst_s_address", 64'(sAddr), 64'd0);
        checkOutput("rst_s_writedata", 64'(sWd), 64'd0);
        checkOutput("rst_m0_readdata", 64'(rd[0]), 64'd0);
        checkOutput("rst_m1_readdata", 64'(rd[1]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // both masters contend from reset: strict alternation starting with m0
        compLog.delete();
        pushReq(0, 1'b0, 2'd0, 32'h11, 1'b0, 0);
        pushReq(0, 1'b0, 2'd0, 32'h33, 1'b0, 0);
        pushReq(1, 1'b0, 2'd0, 32'h22, 1'b0, 0);
        pushReq(1, 1'b0, 2'd0, 32'h44, 1'b0, 0);
        runUntilIdle(40);
        checkOutput("t2_count", 64'(compLog.size()), 64'd4);
        if (compLog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("t2_order%0d", i), 64'(compLog[i].m), 64'(i % 2));
                checkOutput($sformatf("t2_wait_le3_%0d", i), 64'(compLog[i].waits <= 3), 64'd1);
            end
        end

        // single master write: one wait cycle, one slave cycle
        compLog.delete();
        sCsCount = 0;
        pushReq(0, 1'b0, 2'd0, 32'h000000A5, 1'b0, 0);
        runUntilIdle(20);
        runCycle();
        checkOutput("t1_count", 64'(compLog.size()), 64'd1);
        if (compLog.size() == 1) checkOutput("t1_waits", 64'(compLog[0].waits), 64'd1);
        checkOutput("t1_s_cs_cycles", 64'(sCsCount), 64'd1);
        checkOutput("t1_out_port", 64'(outPort), 64'hA5);

        // locked read-modify-write by m1 while m0 keeps asking
        compLog.delete();
        pushReq(1, 1'b1, 2'd0, 32'd0, 1'b1, 0);
        pushReq(1, 1'b0, 2'd0, 32'h0000005A, 1'b0, 0);
        pushReq(0, 1'b1, 2'd0, 32'd0, 1'b0, 0);
        runUntilIdle(40);
        checkOutput("t3_count", 64'(compLog.size()), 64'd3);
        if (compLog.size() == 3) begin
            checkOutput("t3_first", 64'(compLog[0].m), 64'd1);
            checkOutput("t3_read", 64'(compLog[0].rd), 64'hA5);
            checkOutput("t3_second", 64'(compLog[1].m), 64'd1);
            checkOutput("t3_third", 64'(compLog[2].m), 64'd0);
            checkOutput("t3_m0_gap", 64'(compLog[2].cyc - compLog[1].cyc), 64'd2);
            checkOutput("t3_m0_read", 64'(compLog[2].rd), 64'h5A);
        end
        checkOutput("t3_out_port", 64'(outPort), 64'h5A);

        // readback: addr 1 reads zero, addr 0 returns latch
        compLog.delete();
        pushReq(0, 1'b0, 2'd0, 32'h0000003C, 1'b0, 0);
        pushReq(0, 1'b1, 2'd1, 32'd0, 1'b0, 0);
        pushReq(0, 1'b1, 2'd0, 32'd0, 1'b0, 0);
        runUntilIdle(40);
        checkOutput("t4_count", 64'(compLog.size()), 64'd3);
        if (compLog.size() == 3) begin
            checkOutput("t4_rd_addr1", 64'(compLog[1].rd), 64'd0);
            checkOutput("t4_rd_addr0", 64'(compLog[2].rd), 64'h3C);
        end

        // m0 takes the lock then walks away; m1 must get in promptly
        compLog.delete();
        pushReq(0, 1'b0, 2'd0, 32'h00000011, 1'b1, 0);
        pushReq(1, 1'b0, 2'd0, 32'h00000077, 1'b0, 1);
        runUntilIdle(40);
        checkOutput("t5_count", 64'(compLog.size()), 64'd2);
        if (compLog.size() == 2) begin
            checkOutput("t5_second", 64'(compLog[1].m), 64'd1);
            checkOutput("t5_release_gap", 64'(compLog[1].cyc - compLog[0].cyc), 64'd2);
        end
        checkOutput("t5_out_port", 64'(outPort), 64'h77);

        // reset in the middle of an m1 grant
        compLog.delete();
        pushReq(1, 1'b0, 2'd0, 32'h000000FF, 1'b0, 0);
        for (int i = 0; i < 10 && mGrantee != 1; i++) runCycle();
        checkOutput("t6_in_grant", 64'(sCs), 64'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_cs_async", 64'(sCs), 64'd0);
        checkOutput("t6_m1_readdata", 64'(rd[1]), 64'd0);
        clearAgents();
        modelReset();
        @(negedge clk);
        checkOutput("t6_out_port", 64'(outPort), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        compLog.delete();
        pushReq(0, 1'b1, 2'd0, 32'd0, 1'b0, 0);
        pushReq(1, 1'b1, 2'd0, 32'd0, 1'b0, 0);
        runUntilIdle(20);
        checkOutput("t6_count", 64'(compLog.size()), 64'd2);
        if (compLog.size() == 2) checkOutput("t6_first_after_reset", 64'(compLog[0].m), 64'd0);

        // random traffic with locks, idle gaps and abandoned requests
        randMode = 1'b1;
        repeat (1500) runCycle();
        randMode = 1'b0;
        for (int x = 0; x < 2; x++) if (!cs[x]) lk[x] = 1'b0;
        runUntilIdle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
